mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_timer.sv | 25 ++
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default parameters for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2
    } arb_state_t;

    localparam int TIMEOUT_DEF      = 63;
    localparam int STARVE_LIMIT_DEF = 3;

endpackage

// File: rtl/mem_arb_timer.sv
// Counts BUSY cycles without mem_done; expired flags the cycle in which the
// count reaches TIMEOUT, so the arbiter can abort on the following edge.
module mem_arb_timer #(
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [5:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + 6'd1;
        end
    end

    assign expired = enable && ((r_cnt + 6'd1) == 6'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one single-outstanding memory port,
// with data priority bounded by a starvation counter, alignment and timeout errors.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT      = TIMEOUT_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic [15:0] i_rdata,
    output logic [15:0] d_rdata,
    output logic        i_done,
    output logic        d_done,
    output logic        i_stall,
    output logic        d_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        err
);

    localparam logic [1:0] W_LIM = 2'(STARVE_LIMIT);

    arb_state_t  r_state, w_state_nxt;
    logic [1:0]  r_starve, w_starve_nxt;
    logic        r_mem_en, w_mem_en_nxt;
    logic        r_mem_wr, w_mem_wr_nxt;
    logic [15:0] r_mem_addr, w_mem_addr_nxt;
    logic [15:0] r_mem_wdata, w_mem_wdata_nxt;
    logic        r_i_done, w_i_done_nxt;
    logic        r_d_done, w_d_done_nxt;
    logic [15:0] r_i_rdata, w_i_rdata_nxt;
    logic [15:0] r_d_rdata, w_d_rdata_nxt;
    logic        r_err, w_err_nxt;
    logic        r_dropped, w_dropped_nxt;

    logic w_i_ok, w_d_ok, w_i_bad, w_d_bad, w_pick_i, w_pick_d, w_expired;

    // Misaligned requests are never eligible; they only raise err.
    assign w_i_ok   = i_req && !i_addr[0];
    assign w_d_ok   = d_req && !d_addr[0];
    assign w_i_bad  = i_req && i_addr[0];
    assign w_d_bad  = d_req && d_addr[0];
    assign w_pick_i = w_i_ok && (!w_d_ok || (r_starve == W_LIM));
    assign w_pick_d = w_d_ok && !w_pick_i;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (r_state == IDLE),
        .enable  ((r_state != IDLE) && !mem_done),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_starve    <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_err       <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_starve    <= w_starve_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_i_done    <= w_i_done_nxt;
            r_d_done    <= w_d_done_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_err       <= w_err_nxt;
            r_dropped   <= w_dropped_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_starve_nxt    = r_starve;
        w_mem_en_nxt    = 1'b0;
        w_mem_wr_nxt    = r_mem_wr;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_i_done_nxt    = 1'b0;
        w_d_done_nxt    = 1'b0;
        w_i_rdata_nxt   = '0;
        w_d_rdata_nxt   = '0;
        w_err_nxt       = 1'b0;
        w_dropped_nxt   = r_dropped;

        case (r_state)
            IDLE: begin
                w_dropped_nxt = 1'b0;
                w_err_nxt     = w_i_bad || w_d_bad;
                if (w_pick_i) begin
                    w_state_nxt     = I_BUSY;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_wr_nxt    = 1'b0;
                    w_mem_addr_nxt  = i_addr;
                    w_mem_wdata_nxt = '0;
                    w_starve_nxt    = '0;
                end else if (w_pick_d) begin
                    w_state_nxt     = D_BUSY;
                    w_mem_en_nxt    = 1'b1;
                    w_mem_wr_nxt    = d_wr;
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    if (i_req && (r_starve != W_LIM)) begin
                        w_starve_nxt = r_starve + 2'd1;
                    end
                end
            end
            I_BUSY: begin
                w_dropped_nxt = r_dropped || !i_req;
                if (mem_done) begin
                    w_state_nxt = IDLE;
                    // A requester that walked away gets err instead of data.
                    if (r_dropped || !i_req) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_i_done_nxt  = 1'b1;
                        w_i_rdata_nxt = mem_rdata;
                    end
                end else if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            D_BUSY: begin
                w_dropped_nxt = r_dropped || !d_req;
                if (mem_done) begin
                    w_state_nxt = IDLE;
                    if (r_dropped || !d_req) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_d_done_nxt  = 1'b1;
                        w_d_rdata_nxt = r_mem_wr ? 16'h0000 : mem_rdata;
                    end
                end else if (w_expired) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign mem_en    = r_mem_en;
    assign mem_wr    = r_mem_wr;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign i_done    = r_i_done;
    assign d_done    = r_d_done;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign err       = r_err;
    assign i_stall   = i_req && !r_i_done;
    assign d_stall   = d_req && !r_d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-transaction vector table plus
// hand-written sequences for arbitration order, starvation, timeout, drop and reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic [15:0] i_rdata, d_rdata;
    logic        i_done, d_done, i_stall, d_stall;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .i_rdata(i_rdata), .d_rdata(d_rdata),
        .i_done(i_done), .d_done(d_done),
        .i_stall(i_stall), .d_stall(d_stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .err(err)
    );

    typedef struct {
        logic        i_req;
        logic [15:0] i_addr;
        logic        d_req;
        logic        d_wr;
        logic [15:0] d_addr;
        logic [15:0] d_wdata;
        logic [15:0] rd;
        logic        e_en;
        logic        e_wr;
        logic [15:0] e_addr;
        logic [15:0] e_wdata;
        logic        e_err;
        logic        e_idone;
        logic        e_ddone;
        logic [15:0] e_irdata;
        logic [15:0] e_drdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        mem_done = 1'b0; mem_rdata = '0;
        step(); step();
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_early;
        logic [15:0] exp_addr;

        //          ireq iaddr     dreq dwr daddr     dwdata    rd        en wr addr      wdata     err idn ddn irdata    drdata
        vecs[0] = '{1'b1, 16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h5A5A, 16'h0000};
        vecs[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h1234, 1'b1, 1'b0, 16'h0200, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234};
        vecs[2] = '{1'b1, 16'h0040, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 16'h7777, 1'b1, 1'b1, 16'h0100, 16'hBEEF, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[4] = '{1'b1, 16'h0011, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 16'h0020, 1'b1, 1'b0, 16'h0005, 16'h0000, 16'h3C3C, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h3C3C, 16'h0000};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'hFFFE, 16'h0001, 16'hAAAA, 1'b1, 1'b1, 16'hFFFE, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000};

        // Reset state
        step(); step();
        chk("reset mem_en", mem_en, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset err", err, 0);
        chk("reset done", {i_done, d_done, i_stall, d_stall}, 0);

        // Single-transaction table
        for (int v = 0; v < 7; v++) begin
            do_reset();
            i_req = vecs[v].i_req; i_addr = vecs[v].i_addr;
            d_req = vecs[v].d_req; d_wr = vecs[v].d_wr;
            d_addr = vecs[v].d_addr; d_wdata = vecs[v].d_wdata;
            step();
            chk($sformatf("v%0d mem_en", v), mem_en, vecs[v].e_en);
            chk($sformatf("v%0d mem_wr", v), mem_wr, vecs[v].e_wr);
            chk($sformatf("v%0d mem_addr", v), mem_addr, vecs[v].e_addr);
            chk($sformatf("v%0d mem_wdata", v), mem_wdata, vecs[v].e_wdata);
            chk($sformatf("v%0d err", v), err, vecs[v].e_err);
            chk($sformatf("v%0d stall", v), {i_stall, d_stall}, {vecs[v].i_req, vecs[v].d_req});
            if (vecs[v].e_en) begin
                step();
                chk($sformatf("v%0d mem_en 2nd", v), mem_en, 0);
                mem_done = 1'b1; mem_rdata = vecs[v].rd;
                step();
                chk($sformatf("v%0d done", v), {i_done, d_done}, {vecs[v].e_idone, vecs[v].e_ddone});
                chk($sformatf("v%0d i_rdata", v), i_rdata, vecs[v].e_irdata);
                chk($sformatf("v%0d d_rdata", v), d_rdata, vecs[v].e_drdata);
                chk($sformatf("v%0d err at done", v), err, 0);
                mem_done = 1'b0;
            end
            i_req = 1'b0; d_req = 1'b0;
        end

        // Data wins, fetch follows immediately after d_done
        do_reset();
        i_req = 1'b1; i_addr = 16'h0040;
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0100; d_wdata = 16'hBEEF;
        step();
        chk("seq mem_wr", mem_wr, 1);
        chk("seq mem_addr d", mem_addr, 16'h0100);
        step();
        mem_done = 1'b1; mem_rdata = 16'h1357;
        step();
        chk("seq d_done", d_done, 1);
        chk("seq d_rdata", d_rdata, 0);
        chk("seq i_stall", i_stall, 1);
        d_req = 1'b0; mem_done = 1'b0;
        step();
        chk("seq fetch mem_en", mem_en, 1);
        chk("seq fetch mem_addr", mem_addr, 16'h0040);
        chk("seq fetch mem_wr", mem_wr, 0);
        step();
        mem_done = 1'b1; mem_rdata = 16'h0F0F;
        step();
        chk("seq i_done", i_done, 1);
        chk("seq i_rdata", i_rdata, 16'h0F0F);
        chk("seq i_stall at done", i_stall, 0);
        i_req = 1'b0; mem_done = 1'b0;

        // Starvation: grant order D D D I D
        do_reset();
        i_req = 1'b1; i_addr = 16'h0080;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0300; d_wdata = '0;
        for (int g = 0; g < 5; g++) begin
            int w;
            w = 0;
            while (!mem_en && w < 6) begin
                step();
                w++;
            end
            chk($sformatf("starve g%0d grant", g), mem_en, 1);
            exp_addr = (g == 3) ? 16'h0080 : 16'h0300;
            chk($sformatf("starve g%0d addr", g), mem_addr, exp_addr);
            step();
            mem_done = 1'b1; mem_rdata = 16'h00A0 + 16'(g);
            step();
            chk($sformatf("starve g%0d done", g), {i_done, d_done}, (g == 3) ? 2'b10 : 2'b01);
            mem_done = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;

        // Timeout
        do_reset();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0400;
        step();
        chk("tmo mem_en", mem_en, 1);
        n_early = 0;
        for (int k = 2; k <= 63; k++) begin
            step();
            if (err || d_done || mem_en) n_early++;
        end
        chk("tmo early events", n_early, 0);
        step();
        chk("tmo err", err, 1);
        chk("tmo d_done", d_done, 0);
        chk("tmo d_stall", d_stall, 1);
        chk("tmo mem_en idle", mem_en, 0);
        step();
        chk("tmo regrant", mem_en, 1);
        chk("tmo regrant addr", mem_addr, 16'h0400);
        d_req = 1'b0;

        // Requester drops before done
        do_reset();
        i_req = 1'b1; i_addr = 16'h0050;
        step();
        chk("drop mem_en", mem_en, 1);
        i_req = 1'b0;
        step();
        mem_done = 1'b1; mem_rdata = 16'h1111;
        step();
        chk("drop i_done", i_done, 0);
        chk("drop err", err, 1);
        mem_done = 1'b0;
        step();
        chk("drop err one pulse", err, 0);

        // Reset during I_BUSY, late mem_done ignored
        do_reset();
        i_req = 1'b1; i_addr = 16'h0060;
        step();
        chk("rst mem_en", mem_en, 1);
        rst = 1'b0; i_req = 1'b0;
        step();
        chk("rst outs", {mem_en, mem_wr, i_done, d_done, err, i_stall, d_stall}, 0);
        chk("rst mem_addr", mem_addr, 0);
        rst = 1'b1; mem_done = 1'b1; mem_rdata = 16'hDEAD;
        step();
        chk("late done i_done", i_done, 0);
        chk("late done err", err, 0);
        chk("late done i_rdata", i_rdata, 0);
        mem_done = 1'b0;
        step();
        chk("late done after", {mem_en, err, i_done}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
